// File: rtl/c3lib_gate_en_seq.sv
// c3lib_gate_en_seq
//   Produces the registered enable for c3lib_and2_* gating cells. Opening the
//   gate is a level req/ack handshake with a programmable settle time before
//   gate_en rises. Closing drops gate_en at once, but en_ack stays high until
//   a drain time has elapsed.
//
//   en_req must already be synchronous to clk.
//
// Handshake: en_req is a level request. The requester holds en_req stable
//   until en_ack == en_req. If en_req changes early, the FSM still follows its
//   transition rules. gate_en never glitches, and the drain is never cut short.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous reset, active-high
//   en_req   in   level enable request (1 = want gate open)
//   gate_en  out  registered enable, drives in1 of the and2 gating cell
//   en_ack   out  registered level ack, mirrors en_req once its sequence completes
//   busy     out  registered, 1 while in ON_WAIT or OFF_WAIT
module c3lib_gate_en_seq #(
    parameter int ON_DLY  = 4,
    parameter int OFF_DLY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_req,
    output logic gate_en,
    output logic en_ack,
    output logic busy
);

    localparam int MAX_DLY = (ON_DLY > OFF_DLY) ? ON_DLY : OFF_DLY;
    localparam int CNT_W   = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY + 1);

    // The counter is loaded with delay-1 on entry to a wait state. The wait
    // state then ends on the edge that finds cnt at zero.
    localparam logic [CNT_W-1:0] ON_LOAD  = (ON_DLY  > 0) ? CNT_W'(ON_DLY  - 1) : '0;
    localparam logic [CNT_W-1:0] OFF_LOAD = (OFF_DLY > 0) ? CNT_W'(OFF_DLY - 1) : '0;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        ON_WAIT  = 2'd1,
        ON       = 2'd2,
        OFF_WAIT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OFF: begin
                if (en_req) begin
                    if (ON_DLY == 0) begin
                        state_nxt = ON;
                    end else begin
                        state_nxt = ON_WAIT;
                        cnt_nxt   = ON_LOAD;
                    end
                end
            end
            ON_WAIT: begin
                if (!en_req) begin
                    state_nxt = OFF;
                end else if (cnt == '0) begin
                    state_nxt = ON;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ON: begin
                if (!en_req) begin
                    if (OFF_DLY == 0) begin
                        state_nxt = OFF;
                    end else begin
                        state_nxt = OFF_WAIT;
                        cnt_nxt   = OFF_LOAD;
                    end
                end
            end
            OFF_WAIT: begin
                // The drain ignores en_req, so the gated logic always gets its full drain time.
                if (cnt == '0) begin
                    state_nxt = OFF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state. They therefore equal decodes
    // of the current state, with no combinational path to the gating cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            cnt     <= '0;
            gate_en <= 1'b0;
            en_ack  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gate_en <= (state_nxt == ON);
            en_ack  <= (state_nxt == ON) || (state_nxt == OFF_WAIT);
            busy    <= (state_nxt == ON_WAIT) || (state_nxt == OFF_WAIT);
        end
    end

endmodule

// File: tb/tb_c3lib_gate_en_seq.sv
// Bench for c3lib_gate_en_seq: one instance with the default delays (4/8)
// and one with zero delays, driven side by side from a shared clock.
module tb_c3lib_gate_en_seq;

    localparam int ON_A  = 4;
    localparam int OFF_A = 8;

    logic clk = 1'b0;
    logic rst_a = 1'b1, req_a = 1'b0;
    logic rst_b = 1'b1, req_b = 1'b0;
    logic gate_a, ack_a, busy_a;
    logic gate_b, ack_b, busy_b;

    int n_checks = 0;
    int n_err    = 0;

    logic [5:0] exp_q[$];

    // Reference model state: 0 off, 1 rising, 2 on, 3 draining; rem = edges still to wait
    int ms_a = 0, mr_a = 0, ms_b = 0, mr_b = 0;

    // Property tracking for instance a
    int   run_a = 0;
    int   fell_cnt = 0;
    logic fell_active = 1'b0;
    logic prev_gate = 1'b0, prev_ack = 1'b0;

    always #5 clk = ~clk;

    c3lib_gate_en_seq #(.ON_DLY(ON_A), .OFF_DLY(OFF_A)) dut (
        .clk(clk), .rst(rst_a), .en_req(req_a),
        .gate_en(gate_a), .en_ack(ack_a), .busy(busy_a)
    );

    c3lib_gate_en_seq #(.ON_DLY(0), .OFF_DLY(0)) dut0 (
        .clk(clk), .rst(rst_b), .en_req(req_b),
        .gate_en(gate_b), .en_ack(ack_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Each wait counts down the remaining edges and leaves
    // the wait on the edge that reaches zero.
    task automatic model(input int ond, input int offd, input logic r, input logic q,
                         inout int st, inout int rem, output logic [2:0] o);
        if (r) begin
            st = 0; rem = 0;
        end else begin
            case (st)
                0: if (q) begin
                       if (ond == 0) st = 2;
                       else begin st = 1; rem = ond; end
                   end
                1: if (!q) st = 0;
                   else begin rem--; if (rem == 0) st = 2; end
                2: if (!q) begin
                       if (offd == 0) st = 0;
                       else begin st = 3; rem = offd; end
                   end
                default: begin rem--; if (rem == 0) st = 0; end
            endcase
        end
        o = {st == 2, (st == 2) || (st == 3), (st == 1) || (st == 3)};
    endtask

    // One clock: drive inputs at negedge, push the expected outputs, compare after posedge.
    task automatic step(input logic ra, input logic qa, input logic rb, input logic qb);
        logic [2:0] oa, ob;
        logic [5:0] e;
        @(negedge clk);
        rst_a = ra; req_a = qa; rst_b = rb; req_b = qb;
        model(ON_A, OFF_A, ra, qa, ms_a, mr_a, oa);
        model(0, 0, rb, qb, ms_b, mr_b, ob);
        exp_q.push_back({oa, ob});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("a_gate_en", gate_a, e[5]);
        check("a_en_ack",  ack_a,  e[4]);
        check("a_busy",    busy_a, e[3]);
        check("b_gate_en", gate_b, e[2]);
        check("b_en_ack",  ack_b,  e[1]);
        check("b_busy",    busy_b, e[0]);
        // gate_en may only rise after a complete ON_DLY wait, and en_ack may only
        // fall after the full drain that follows the gate_en fall.
        if (ra) begin
            run_a = 0; fell_active = 1'b0;
        end else begin
            if (gate_a && !prev_gate) check("on_wait_full", run_a, ON_A);
            if (busy_a && !ack_a) run_a++; else run_a = 0;
            if (!gate_a && prev_gate) begin
                fell_active = 1'b1; fell_cnt = 0;
            end else if (fell_active) begin
                fell_cnt++;
            end
            if (!ack_a && prev_ack) begin
                check("drain_min", fell_active && (fell_cnt >= OFF_A), 1);
                fell_active = 1'b0;
            end
        end
        prev_gate = gate_a; prev_ack = ack_a;
    endtask

    initial begin
        int n;
        logic ra, qa, rb, qb;

        // 1. reset, then a basic open/close
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check("rst_gate", gate_a, 0);
        check("rst_ack", ack_a, 0);
        check("rst_busy", busy_a, 0);
        n = 0;
        do begin step(0, 1, 1, 0); n++; end while (gate_a !== 1'b1 && n < 20);
        check("on_latency", n, ON_A + 1);
        check("on_ack_with_gate", ack_a, 1);
        step(0, 0, 1, 0);
        n = 1;
        check("gate_fall_1edge", gate_a, 0);
        check("drain_busy", busy_a, 1);
        while (ack_a === 1'b1 && n < 20) begin step(0, 0, 1, 0); n++; end
        check("ack_fall_latency", n, OFF_A + 1);

        // 2. abort during ON_WAIT
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        check("abort_busy_pre", busy_a, 1);
        step(0, 0, 1, 0);
        check("abort_busy", busy_a, 0);
        check("abort_gate", gate_a, 0);
        check("abort_ack", ack_a, 0);

        // 3. re-request during OFF_WAIT
        n = 0;
        do begin step(0, 1, 1, 0); n++; end while (gate_a !== 1'b1 && n < 20);
        check("reopen_on", gate_a, 1);
        step(0, 0, 1, 0);
        n = 1;
        do begin step(0, 1, 1, 0); n++; end while (gate_a !== 1'b1 && n < 40);
        check("rereq_latency", n, OFF_A + 1 + ON_A + 1);

        // 4. zero delays: outputs follow en_req one edge later
        step(1, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            qb = ((i / 3) % 2) == 0;
            step(1, 0, 0, qb);
            check("zero_follow_gate", gate_b, qb);
            check("zero_follow_ack", ack_b, qb);
            check("zero_busy", busy_b, 0);
        end

        // 5. reset mid-sequence: in ON, in ON_WAIT with cnt=2, in OFF_WAIT with cnt=5
        n = 0;
        do begin step(0, 1, 1, 0); n++; end while (gate_a !== 1'b1 && n < 20);
        step(1, 1, 1, 0);
        check("rst_on_all0", {gate_a, ack_a, busy_a}, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        check("on_wait_cnt2", dut.cnt, 2);
        step(1, 1, 1, 0);
        check("rst_onwait_all0", {gate_a, ack_a, busy_a}, 0);
        n = 0;
        do begin step(0, 1, 1, 0); n++; end while (gate_a !== 1'b1 && n < 20);
        check("restart_latency", n, ON_A + 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("off_wait_cnt5", dut.cnt, 5);
        step(1, 0, 1, 0);
        check("rst_offwait_all0", {gate_a, ack_a, busy_a}, 0);

        // Random traffic on both instances, including handshake violations and resets
        qa = 1'b0; qb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 6) == 0) qa = ~qa;
            if ($urandom_range(0, 3) == 0) qb = ~qb;
            ra = ($urandom_range(0, 80) == 0);
            rb = ($urandom_range(0, 80) == 0);
            step(ra, qa, rb, qb);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
